// File: rtl/drum_access_ctrl.sv
// drum_access_ctrl
// Sequences one drum-store read or write per request. A free-running tick
// counter models the angular position of the drum. A request latches its
// address, which selects a sector. The controller waits for the next boundary
// of that sector, issues a single-cycle memory strobe, captures read data one
// cycle later, and then pulses access_done.

module drum_access_ctrl #(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 31,
  parameter int SECTOR_W      = 6,
  parameter int SECTOR_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_access,
  input  logic                access_write,
  input  logic [ADDR_W-1:0]   reg_select_value,
  input  logic [DATA_W-1:0]   write_data,
  output logic                busy,
  output logic                access_done,
  output logic [DATA_W-1:0]   read_data,
  output logic [SECTOR_W-1:0] drum_pos,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  // The tick counter needs at least one bit even for the minimum of two
  // clocks per sector.
  localparam int TICK_W = (SECTOR_CYCLES > 2) ? $clog2(SECTOR_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SECTOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    XFER    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t              state_q;

  logic [TICK_W-1:0]   tick_q;
  logic [TICK_W-1:0]   tick_d;
  logic [SECTOR_W-1:0] pos_q;
  logic [SECTOR_W-1:0] pos_d;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;

  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q;
  logic                done_q;
  logic                mem_en_q;
  logic                mem_we_q;

  logic                boundary;
  logic                sector_hit;

  // Advance the drum one tick per clock; bump the sector on the last tick.
  always_comb begin
    tick_d = tick_q + TICK_W'(1);
    pos_d  = pos_q;
    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      pos_d  = pos_q + SECTOR_W'(1);
    end
  end

  // Drum position registers; free-running in every FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= '0;
      pos_q  <= '0;
    end else begin
      tick_q <= tick_d;
      pos_q  <= pos_d;
    end
  end

  // The target sector is under the heads on the first tick of that sector.
  assign boundary   = (tick_q == '0);
  assign sector_hit = boundary && (pos_q == addr_q[SECTOR_W-1:0]);

  // Access sequencer: state and all of its outputs are registered together,
  // so each output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_access) begin
            addr_q  <= reg_select_value;
            wdata_q <= write_data;
            we_q    <= access_write;
            busy_q  <= 1'b1;
            state_q <= SEEK;
          end
        end
        SEEK: begin
          // The match is only looked for once SEEK is entered, so the
          // boundary that coincides with the request cycle is skipped.
          if (sector_hit) begin
            mem_en_q <= 1'b1;
            mem_we_q <= we_q;
            state_q  <= XFER;
          end
        end
        XFER: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          // Synchronous memory returns the word one cycle after the strobe.
          if (!we_q) begin
            rdata_q <= mem_rdata;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign access_done = done_q;
  assign read_data   = rdata_q;
  assign drum_pos    = pos_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  // Track bits above the sector field pass straight through to the memory.
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_drum_access_ctrl.sv
// tb_drum_access_ctrl
// Directed bench for drum_access_ctrl with four clocks per sector. Cycle k=0
// is the first cycle after reset drops; drum_pos = (k/4) mod 64 and a sector
// boundary is any cycle with k mod 4 == 0.

module tb_drum_access_ctrl;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 31;
  localparam int SECTOR_W = 6;
  localparam int SC       = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                start_access;
  logic                access_write;
  logic [ADDR_W-1:0]   reg_select_value;
  logic [DATA_W-1:0]   write_data;
  logic                busy;
  logic                access_done;
  logic [DATA_W-1:0]   read_data;
  logic [SECTOR_W-1:0] drum_pos;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  logic [DATA_W-1:0]   rd_word;

  int n_chk = 0;
  int n_bad = 0;
  int k;
  int en_cnt, en_k, done_cnt, done_k;
  logic              en_we;
  logic [ADDR_W-1:0] en_addr;
  logic [DATA_W-1:0] en_wdata;

  drum_access_ctrl #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .SECTOR_W     (SECTOR_W),
    .SECTOR_CYCLES(SC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start_access    (start_access),
    .access_write    (access_write),
    .reg_select_value(reg_select_value),
    .write_data      (write_data),
    .busy            (busy),
    .access_done     (access_done),
    .read_data       (read_data),
    .drum_pos        (drum_pos),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory: the read word appears only the cycle after a read
  // strobe; any other cycle returns a poison value.
  always @(posedge clk) begin
    mem_rdata <= (mem_en && !mem_we) ? rd_word : 31'h2BADBAD;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic clr_mon();
    en_cnt = 0; en_k = -1; done_cnt = 0; done_k = -1;
    en_we = 1'b0; en_addr = '0; en_wdata = '0;
  endtask

  // Advance one cycle; sample outputs 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
    k++;
    if (mem_en === 1'b1) begin
      en_cnt++; en_k = k; en_we = mem_we; en_addr = mem_addr; en_wdata = mem_wdata;
    end
    if (access_done === 1'b1) begin
      done_cnt++; done_k = k;
    end
  endtask

  // Leaves the bench in cycle k=0.
  task automatic do_reset();
    reset = 1'b1;
    start_access = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    k = 0;
    clr_mon();
  endtask

  task automatic request(input logic [ADDR_W-1:0] a, input logic w, input logic [DATA_W-1:0] d);
    start_access     = 1'b1;
    reg_select_value = a;
    access_write     = w;
    write_data       = d;
  endtask

  initial begin
    int busy_err;
    int pos_err;

    reset = 1'b1;
    start_access = 1'b0;
    access_write = 1'b0;
    reg_select_value = '0;
    write_data = '0;
    rd_word = '0;

    // ---- reset state ----
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", access_done, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_pos", drum_pos, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);

    // ---- read hit, sector 3 ----
    rd_word = 31'h1234567;
    step();                               // k=1
    request(12'o0003, 1'b0, 31'h0);
    busy_err = 0;
    while (k < 15) begin
      step();
      start_access = 1'b0;
      if (k <= 14 && busy !== 1'b1) busy_err++;
    end
    chk("rd_busy_2_14", busy_err, 0);
    chk("rd_en_cnt", en_cnt, 1);
    chk("rd_en_k", en_k, 13);
    chk("rd_en_we", en_we, 0);
    chk("rd_en_addr", en_addr, 12'o0003);
    chk("rd_done_k", done_k, 15);
    chk("rd_done_cnt", done_cnt, 1);
    chk("rd_data", read_data, 31'h1234567);
    chk("rd_busy_done", busy, 0);
    step();                               // k=16
    chk("rd_done_once", access_done, 0);

    // ---- write, sector 2 with track bits set ----
    do_reset();
    rd_word = 31'h1111111;
    step();                               // k=1
    request(12'o7702, 1'b1, 31'h5);
    while (k < 12) begin
      step();
      start_access = 1'b0;
    end
    chk("wr_en_k", en_k, 9);
    chk("wr_en_we", en_we, 1);
    chk("wr_en_addr", en_addr, 12'o7702);
    chk("wr_en_wdata", en_wdata, 31'h5);
    chk("wr_done_k", done_k, 11);
    chk("wr_rdata_hold", read_data, 0);

    // ---- full revolution to sector 0 ----
    do_reset();
    rd_word = 31'h0C0FFEE;
    step();                               // k=1
    request(12'o0000, 1'b0, 31'h0);
    while (k < 259) begin
      step();
      start_access = 1'b0;
      if (k == 255) chk("wrap_pos_255", drum_pos, 63);
      if (k == 256) chk("wrap_pos_256", drum_pos, 0);
    end
    chk("wrap_en_cnt", en_cnt, 1);
    chk("wrap_en_k", en_k, 257);
    chk("wrap_done_k", done_k, 259);
    chk("wrap_rdata", read_data, 31'h0C0FFEE);

    // ---- second request while busy is ignored; done cycle accepts ----
    do_reset();
    rd_word = 31'h0AAAAAA;
    step();                               // k=1
    request(12'o0003, 1'b0, 31'h0);
    while (k < 15) begin
      step();
      start_access = 1'b0;
      if (k == 5) request(12'o0001, 1'b1, 31'h7);
    end
    chk("ign_en_cnt", en_cnt, 1);
    chk("ign_en_addr", en_addr, 12'o0003);
    chk("ign_en_we", en_we, 0);
    chk("ign_done_k", done_k, 15);
    chk("ign_rdata", read_data, 31'h0AAAAAA);
    clr_mon();
    rd_word = 31'h0555555;
    request(12'o0005, 1'b0, 31'h0);       // issued in the done cycle
    step();                               // k=16
    start_access = 1'b0;
    chk("acc_busy", busy, 1);
    while (k < 24) step();
    chk("acc_en_addr", en_addr, 12'o0005);
    chk("acc_en_k", en_k, 21);
    chk("acc_done_k", done_k, 23);
    chk("acc_rdata", read_data, 31'h0555555);

    // ---- reset during SEEK aborts the access ----
    do_reset();
    step();                               // k=1
    request(12'o0003, 1'b0, 31'h0);
    while (k < 5) begin
      step();
      start_access = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    k = 0;
    clr_mon();
    chk("mid_busy", busy, 0);
    chk("mid_pos", drum_pos, 0);
    while (k < 20) begin
      step();
      if (k == 3) chk("mid_pos_3", drum_pos, 0);
      if (k == 4) chk("mid_pos_4", drum_pos, 1);
    end
    chk("mid_en_cnt", en_cnt, 0);
    chk("mid_done_cnt", done_cnt, 0);

    // ---- idle position walk ----
    do_reset();
    pos_err = 0;
    while (k < 300) begin
      step();
      if (drum_pos !== SECTOR_W'((k / SC) % 64)) pos_err++;
    end
    chk("pos_walk_err", pos_err, 0);
    chk("pos_300", drum_pos, 11);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
